// File: rtl/fetch_stage_if.sv
// Bundle between the fetch stage, instruction memory and decode.
//  master : the fetch stage (drives the request and the decode-side head entry)
//  slave  : memory/decode side (drives ack/rdata and the decode stall)
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, stall
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, stall
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch front end.
// Holds the PC, fetches words over a req/ack port, buffers {inst, pc} pairs
// in a small FIFO and presents the head entry to decode. pred_miss flushes
// the buffer and restarts fetch at the redirect PC; a request already on the
// bus when the flush arrives is completed and its data discarded (DROP).
// Optional macro FETCH_PERF_CNT_EN adds fetch/drop performance counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_pred_miss,
    input  logic [31:0]   i_redirect_pc,
    fetch_stage_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   o_perf_fetch_cnt,
    output logic [31:0]   o_perf_drop_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      w_pc_next;
    logic [31:0]      r_addr;
    logic [31:0]      w_addr_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_cnt_after_pop;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [31:0]      r_fifo_inst [FIFO_DEPTH];
    logic [31:0]      r_fifo_pc   [FIFO_DEPTH];
    logic             w_xfer;
    logic             w_push;
    logic             w_pop;

    // Handshake and FIFO occupancy bookkeeping; flush overrides push and pop.
    always_comb begin
        w_xfer          = (r_state != ST_IDLE) && bus.imem_ack;
        w_push          = (r_state == ST_REQ) && bus.imem_ack && !i_pred_miss;
        w_pop           = (r_count != {CNT_W{1'b0}}) && !bus.stall && !i_pred_miss;
        w_cnt_after_pop = r_count - CNT_W'(w_pop);
        if (i_pred_miss) begin
            w_count_next = {CNT_W{1'b0}};
        end else begin
            w_count_next = w_cnt_after_pop + CNT_W'(w_push);
        end
    end

    // Next fetch state, PC and presented address.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (i_pred_miss || (w_cnt_after_pop < DEPTH_C)) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.imem_ack) begin
                    if (i_pred_miss || (w_count_next < DEPTH_C)) begin
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (i_pred_miss) begin
                    w_state_next = ST_DROP;
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DROP: begin
                if (bus.imem_ack) begin
                    if (w_count_next < DEPTH_C) begin
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_DROP;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (i_pred_miss) begin
            w_pc_next = {i_redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            w_pc_next = r_pc + 32'd4;
        end else begin
            w_pc_next = r_pc;
        end

        // An unacknowledged (dropped) request must keep its address stable.
        if (w_state_next == ST_DROP) begin
            w_addr_next = r_addr;
        end else begin
            w_addr_next = w_pc_next;
        end
    end

    // State, PC, address and FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_count <= {CNT_W{1'b0}};
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            r_count <= w_count_next;
            if (i_pred_miss) begin
                r_wptr <= {PTR_W{1'b0}};
                r_rptr <= {PTR_W{1'b0}};
            end else begin
                r_wptr <= r_wptr + PTR_W'(w_push);
                r_rptr <= r_rptr + PTR_W'(w_pop);
            end
        end
    end

    // FIFO storage: write the acked word together with the address it came from.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_inst[i] <= 32'h0000_0000;
                r_fifo_pc[i]   <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_fifo_inst[r_wptr] <= bus.imem_rdata;
            r_fifo_pc[r_wptr]   <= r_addr;
        end else begin
            r_fifo_inst[r_wptr] <= r_fifo_inst[r_wptr];
        end
    end

    assign bus.imem_req   = (r_state != ST_IDLE);
    assign bus.imem_addr  = r_addr;
    assign bus.inst_valid = (r_count != {CNT_W{1'b0}});
    assign bus.inst       = r_fifo_inst[r_rptr];
    assign bus.inst_pc    = r_fifo_pc[r_rptr];

`ifdef FETCH_PERF_CNT_EN
    logic        w_discard;
    logic [31:0] w_drop_inc;
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_drop_cnt;

    // Words lost to a flush: buffered entries plus any acked word thrown away.
    always_comb begin
        w_discard  = w_xfer && ((r_state == ST_DROP) || i_pred_miss);
        w_drop_inc = (i_pred_miss ? 32'(r_count) : 32'd0) + (w_discard ? 32'd1 : 32'd0);
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch_cnt <= 32'd0;
            r_perf_drop_cnt  <= 32'd0;
        end else begin
            r_perf_fetch_cnt <= r_perf_fetch_cnt + (w_push ? 32'd1 : 32'd0);
            r_perf_drop_cnt  <= r_perf_drop_cnt + w_drop_inc;
        end
    end

    assign o_perf_fetch_cnt = r_perf_fetch_cnt;
    assign o_perf_drop_cnt  = r_perf_drop_cnt;
`endif
endmodule
